// File: rtl/wfid_decoder_pkg.sv
// -----------------------------------------------------------------------------
// wfid_decoder_pkg
// Shared wavefront-slot constants used by the slot decoder and the matching
// index encoder, so both sides agree on the slot count and index width.
//   WFID_NUM_WF : number of wavefront slots (one-hot width)
//   WFID_ID_W   : width of a slot index
//   wfidInRange : helper telling whether an index names a real slot
// -----------------------------------------------------------------------------
package wfid_decoder_pkg;

   localparam int WFID_NUM_WF = 40;
   localparam int WFID_ID_W   = 6;

   // A slot index is meaningful only when it is below the slot count; the
   // index field is wider than needed, so the top codes are unused.
   function automatic logic wfidInRange(input logic [WFID_ID_W-1:0] idx);
      return 32'(idx) < WFID_NUM_WF;
   endfunction

endpackage

// File: rtl/wfid_decoder_if.sv
// -----------------------------------------------------------------------------
// wfid_decoder_if
// Valid/ready bundle between an index producer, the slot decoder and the
// consumer of the decoded mask.
//   in_valid / in_wfid / in_ready       : index offer into the decoder
//   out_valid / out_onehot / out_err    : decoded result held by the decoder
//   out_ready                           : consumer takes the held result
// Modports:
//   master : the environment side (drives indices, takes results)
//   slave  : the decoder side
// -----------------------------------------------------------------------------
interface wfid_decoder_if
   import wfid_decoder_pkg::*;
#(
   parameter int NUM_WF = WFID_NUM_WF,
   parameter int ID_W   = WFID_ID_W
) ();

   logic              in_valid;
   logic [ID_W-1:0]   in_wfid;
   logic              in_ready;
   logic              out_valid;
   logic [NUM_WF-1:0] out_onehot;
   logic              out_err;
   logic              out_ready;

   modport master (
      output in_valid, in_wfid, out_ready,
      input  in_ready, out_valid, out_onehot, out_err
   );

   modport slave (
      input  in_valid, in_wfid, out_ready,
      output in_ready, out_valid, out_onehot, out_err
   );

endinterface

// File: rtl/wfid_onehot.sv
// -----------------------------------------------------------------------------
// wfid_onehot
// Purely combinational slot-index to one-hot decode.
//   i_idx    : slot index
//   o_onehot : one bit set at position i_idx, all zeros when out of range
//   o_oor    : high when i_idx does not name a slot (i_idx >= NUM_WF)
// -----------------------------------------------------------------------------
module wfid_onehot
   import wfid_decoder_pkg::*;
#(
   parameter int NUM_WF = WFID_NUM_WF,
   parameter int ID_W   = WFID_ID_W
) (
   input  logic [ID_W-1:0]   i_idx,
   output logic [NUM_WF-1:0] o_onehot,
   output logic              o_oor
);

   assign o_oor = !(32'(i_idx) < NUM_WF);

   // Compare against every slot number rather than shifting, so an
   // out-of-range index naturally yields an all-zero mask.
   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         if (32'(i_idx) == i) begin
            o_onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wfid_decoder.sv
// -----------------------------------------------------------------------------
// wfid_decoder
// Decodes a wavefront slot index into a one-hot mask held in a one-entry
// output register with valid/ready flow control, and optionally tracks which
// slots have been decoded but not yet released.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   bus (slave)  : index offer in, decoded mask / range error out
//   clr_valid    : release request
//   clr_wfid     : slot to release
//   pending_mask : slots decoded and not yet released
//   dup_err      : one-cycle pulse when a pending slot is decoded again
// Configuration:
//   WFID_DECODER_PENDING_EN - when defined, builds the pending-slot tracker;
//   otherwise pending_mask and dup_err are tied low and releases are ignored.
// -----------------------------------------------------------------------------
module wfid_decoder
   import wfid_decoder_pkg::*;
#(
   parameter int NUM_WF = WFID_NUM_WF,
   parameter int ID_W   = WFID_ID_W
) (
   input  logic              clk,
   input  logic              rst,
   wfid_decoder_if.slave     bus,
   input  logic              clr_valid,
   input  logic [ID_W-1:0]   clr_wfid,
   output logic [NUM_WF-1:0] pending_mask,
   output logic              dup_err
);

   logic              r_outValid;
   logic [NUM_WF-1:0] r_outOnehot;
   logic              r_outErr;

   logic              w_inReady;
   logic              w_accept;
   logic [NUM_WF-1:0] w_setOnehot;
   logic              w_setOor;

   // The output register can take a new index whenever it is empty or its
   // current content is leaving in this same cycle, giving full throughput.
   assign w_inReady = !r_outValid || bus.out_ready;
   assign w_accept  = bus.in_valid && w_inReady;

   assign bus.in_ready   = w_inReady;
   assign bus.out_valid  = r_outValid;
   assign bus.out_onehot = r_outOnehot;
   assign bus.out_err    = r_outErr;

   wfid_onehot #(.NUM_WF(NUM_WF), .ID_W(ID_W)) u_setDecode (
      .i_idx    (bus.in_wfid),
      .o_onehot (w_setOnehot),
      .o_oor    (w_setOor)
   );

   // Output register: a new accept always overwrites (also when the old
   // result is being taken the same cycle, so no bubble appears); otherwise
   // the result is held until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid  <= 1'b0;
         r_outOnehot <= '0;
         r_outErr    <= 1'b0;
      end else if (w_accept) begin
         r_outValid  <= 1'b1;
         r_outOnehot <= w_setOnehot;
         r_outErr    <= w_setOor;
      end else if (bus.out_ready) begin
         r_outValid  <= 1'b0;
      end
   end

`ifdef WFID_DECODER_PENDING_EN
   logic [NUM_WF-1:0] r_pending;
   logic              r_dupErr;
   logic [NUM_WF-1:0] w_clrOnehot;
   logic              w_clrOor;
   logic [NUM_WF-1:0] w_setMask;
   logic [NUM_WF-1:0] w_clrMask;

   wfid_onehot #(.NUM_WF(NUM_WF), .ID_W(ID_W)) u_clrDecode (
      .i_idx    (clr_wfid),
      .o_onehot (w_clrOnehot),
      .o_oor    (w_clrOor)
   );

   // Out-of-range indices decode to an all-zero mask, so they can neither
   // set nor clear anything without extra gating.
   assign w_setMask = w_accept  ? w_setOnehot : '0;
   assign w_clrMask = clr_valid ? w_clrOnehot : '0;

   // Clear is applied first and set second so a set wins on the same bit.
   // A re-decode only counts as a duplicate if that slot is not being
   // released in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         r_dupErr  <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clrMask) | w_setMask;
         r_dupErr  <= |(w_setMask & r_pending & ~w_clrMask);
      end
   end

   assign pending_mask = r_pending;
   assign dup_err      = r_dupErr;
`else
   wire w_unusedClr = clr_valid ^ (^clr_wfid);

   assign pending_mask = '0;
   assign dup_err      = 1'b0;
`endif

endmodule
